// File: rtl/serializer_pkg.sv
// Shared definitions for the serial transmit path: FSM encodings and idle line level.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: SERIALIZER_PARITY_EN adds the S_PAR state encoding.
package serializer_pkg;

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_PAR   = 2'b10
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01
    } state_t;
`endif

    // Level held on the serial line between words.
    localparam logic IDLE_BIT_DEFAULT = 1'b1;

endpackage

// File: rtl/serializer_skid_buf1.sv
// One-entry holding buffer with valid/ready on both sides.
// Latency: 1 cycle from accept to out_vld; data is held until popped.
// Backpressure: in_rdy is low while the entry is occupied; new data is refused, never overwritten.
// Ports: clk, reset (async active-low), in_vld/in_rdy/in_dat (write side),
//        out_vld/out_rdy/out_dat (read side).
module skid_buf1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    logic             full;
    logic [WIDTH-1:0] dat;

    assign in_rdy  = !full;
    assign out_vld = full;
    assign out_dat = dat;

    // Write and pop are mutually exclusive: a write needs the slot empty,
    // a pop needs it full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            dat  <= '0;
        end else begin
            if (in_vld && in_rdy) begin
                full <= 1'b1;
                dat  <= in_dat;
            end else if (out_vld && out_rdy) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, with a one-word holding buffer for gapless streaming.
// Latency: 1 cycle from accept to MSB on x; back-to-back words leave no idle cycle.
// Backpressure: din_ready = !buf_full; a second word is parked while one shifts, a third waits.
// Ports: clk, reset (async active-low), din/din_valid/din_ready (parallel input),
//        x/x_valid (registered serial output), busy (shifter or buffer occupied).
// Optional feature macro: SERIALIZER_PARITY_EN appends one even-parity bit after each LSB.
module serializer
    import serializer_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;       // bits still to be sent, next one at MSB
    logic [CW-1:0]    cnt;         // bits remaining after the one on x
    logic             word_end;    // x currently shows the final bit of a word
    logic             load;
    logic [WIDTH-1:0] load_dat;
    logic             shift;
    logic             go_idle;
`ifdef SERIALIZER_PARITY_EN
    logic             par;
    logic             par_emit;
`endif

    logic             buf_in_vld;
    logic             buf_full;
    logic [WIDTH-1:0] buf_dat;

    // A word arriving while a word is in flight is parked, except on the
    // final bit with the buffer empty, where it goes straight to the shifter.
    assign buf_in_vld = din_valid && (state != S_IDLE) && !word_end;

    skid_buf1 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (buf_in_vld),
        .in_rdy  (din_ready),
        .in_dat  (din),
        .out_vld (buf_full),
        .out_rdy (word_end),
        .out_dat (buf_dat)
    );

`ifdef SERIALIZER_PARITY_EN
    assign word_end = (state == S_PAR);
`else
    assign word_end = (state == S_SHIFT) && (cnt == '0);
`endif

    assign busy = (state != S_IDLE) || buf_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_dat  = din;
        shift     = 1'b0;
        go_idle   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_emit  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (din_valid && din_ready) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt != '0) begin
                    shift = 1'b1;
                end
`ifdef SERIALIZER_PARITY_EN
                else begin
                    par_emit  = 1'b1;
                    state_nxt = S_PAR;
                end
`endif
            end
            default: ;
        endcase

        // Word boundary: parked word first, then a word offered this cycle
        // (buffer is empty in that branch, so din_valid means accept).
        if (word_end) begin
            if (buf_full) begin
                load      = 1'b1;
                load_dat  = buf_dat;
                state_nxt = S_SHIFT;
            end else if (din_valid) begin
                load      = 1'b1;
                state_nxt = S_SHIFT;
            end else begin
                go_idle   = 1'b1;
                state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            cnt     <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (load) begin
                // MSB goes straight to x; the shifter keeps the rest.
                x       <= load_dat[WIDTH-1];
                x_valid <= 1'b1;
                shreg   <= load_dat << 1;
                cnt     <= CW'(WIDTH - 1);
`ifdef SERIALIZER_PARITY_EN
                par     <= ^load_dat;
`endif
            end else if (shift) begin
                x     <= shreg[WIDTH-1];
                shreg <= shreg << 1;
                cnt   <= cnt - CW'(1);
            end
`ifdef SERIALIZER_PARITY_EN
            else if (par_emit) begin
                x <= par;
            end
`endif
            else if (go_idle) begin
                x       <= IDLE_BIT;
                x_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: scoreboard of expected serial bits,
// filled when a word is accepted and drained as x_valid bits appear.
module tb_serializer;

    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int BITS = W + 1;
`else
    localparam int BITS = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         x;
    logic         x_valid;
    logic         busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    serializer #(
        .WIDTH    (W),
        .IDLE_BIT (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Expected bit stream for one word: MSB first, then parity if enabled.
    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SERIALIZER_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic test_reset;
        reset = 1'b0; din = '0; din_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (x !== 1'b1) begin n_fail++; $display("FAIL reset_x: got %b, expected 1", x); end
        n_checks++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL reset_x_valid: got %b, expected 0", x_valid); end
        n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_din_ready: got %b, expected 1", din_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (x_valid !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL post_reset_idle: got x_valid=%b busy=%b, expected 0 0", x_valid, busy); end
    endtask

    task automatic test_single;
        logic b;
        din = 8'hA5; din_valid = 1'b1;
        n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b, expected 1", din_ready); end
        push_word(8'hA5);
        for (int k = 0; k < BITS; k++) begin
            @(negedge clk);
            din_valid = 1'b0;
            b = exp_q.pop_front();
            n_checks++;
            if (x_valid !== 1'b1 || x !== b) begin
                n_fail++; $display("FAIL single_bit[%0d]: got x_valid=%b x=%b, expected 1 %b", k, x_valid, x, b);
            end
        end
        @(negedge clk);
        n_checks++; if (x_valid !== 1'b0 || x !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_end: got x_valid=%b x=%b busy=%b, expected 0 1 0", x_valid, x, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic b;
        din = 8'h00; din_valid = 1'b1;
        push_word(8'h00);
        for (int k = 0; k < 2 * BITS; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_first: got %b, expected 1", din_ready); end
                din = 8'hFF;
                push_word(8'hFF);
            end else begin
                din_valid = 1'b0;
            end
            b = exp_q.pop_front();
            n_checks++;
            if (x_valid !== 1'b1 || x !== b) begin
                n_fail++; $display("FAIL b2b_bit[%0d]: got x_valid=%b x=%b, expected 1 %b", k, x_valid, x, b);
            end
            if (k == 1 || k == BITS - 1) begin
                n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full[%0d]: got %b, expected 0", k, din_ready); end
            end
            if (k == BITS) begin
                n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_drained: got %b, expected 1", din_ready); end
            end
        end
        @(negedge clk);
        n_checks++; if (x_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: got x_valid=%b busy=%b, expected 0 0", x_valid, busy);
        end
    endtask

    task automatic test_direct_chain;
        logic b;
        din = 8'hC3; din_valid = 1'b1;
        push_word(8'hC3);
        for (int k = 0; k < 2 * BITS; k++) begin
            @(negedge clk);
            if (k == BITS - 1) begin
                n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL chain_ready_last: got %b, expected 1", din_ready); end
                din = 8'h5A; din_valid = 1'b1;
                push_word(8'h5A);
            end else begin
                din_valid = 1'b0;
            end
            b = exp_q.pop_front();
            n_checks++;
            if (x_valid !== 1'b1 || x !== b) begin
                n_fail++; $display("FAIL chain_bit[%0d]: got x_valid=%b x=%b, expected 1 %b", k, x_valid, x, b);
            end
        end
        @(negedge clk);
        n_checks++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL chain_end: got x_valid=%b, expected 0", x_valid); end
    endtask

    // Downstream 0,0,1 sequence detector modelled on the received bits.
    task automatic test_detector;
        logic       b;
        logic [2:0] hist;
        int         nrx;
        int         pulses;
        hist = '0; nrx = 0; pulses = 0;
        din = 8'b0010_0100; din_valid = 1'b1;
        push_word(8'b0010_0100);
        for (int k = 0; k < BITS + 2; k++) begin
            @(negedge clk);
            din_valid = 1'b0;
            if (x_valid === 1'b1) begin
                hist = {hist[1:0], x};
                nrx++;
                if (nrx >= 3 && hist == 3'b001) pulses++;
                b = exp_q.pop_front();
                n_checks++;
                if (x !== b) begin n_fail++; $display("FAIL det_bit[%0d]: got %b, expected %b", k, x, b); end
            end
        end
        n_checks++; if (nrx != BITS) begin n_fail++; $display("FAIL det_nbits: got %0d, expected %0d", nrx, BITS); end
        n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL det_pulses: got %0d, expected 2", pulses); end
    endtask

    task automatic test_reset_mid;
        logic b;
        din = 8'hF0; din_valid = 1'b1;
        push_word(8'hF0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                din = 8'hAA;   // parked in the buffer, must be discarded by reset
            end else begin
                din_valid = 1'b0;
            end
            b = exp_q.pop_front();
            n_checks++;
            if (x_valid !== 1'b1 || x !== b) begin
                n_fail++; $display("FAIL rst_mid_bit[%0d]: got x_valid=%b x=%b, expected 1 %b", k, x_valid, x, b);
            end
        end
        reset = 1'b0;
        #1;
        n_checks++; if (x !== 1'b1 || x_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_async: got x=%b x_valid=%b busy=%b din_ready=%b, expected 1 0 0 1", x, x_valid, busy, din_ready);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (x_valid !== 1'b0 || busy !== 1'b0 || x !== 1'b1) begin
                n_fail++; $display("FAIL rst_mid_quiet[%0d]: got x_valid=%b busy=%b x=%b, expected 0 0 1", k, x_valid, busy, x);
            end
        end
        din = 8'h3C; din_valid = 1'b1;
        push_word(8'h3C);
        for (int k = 0; k < BITS; k++) begin
            @(negedge clk);
            din_valid = 1'b0;
            b = exp_q.pop_front();
            n_checks++;
            if (x_valid !== 1'b1 || x !== b) begin
                n_fail++; $display("FAIL rst_next_bit[%0d]: got x_valid=%b x=%b, expected 1 %b", k, x_valid, x, b);
            end
        end
        @(negedge clk);
        n_checks++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL rst_next_end: got x_valid=%b, expected 0", x_valid); end
    endtask

`ifdef SERIALIZER_PARITY_EN
    task automatic test_parity;
        logic [8:0] lit;
        lit = 9'b0_0000_1111;
        din = 8'h07; din_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            din_valid = 1'b0;
            n_checks++;
            if (x_valid !== 1'b1 || x !== lit[8-k]) begin
                n_fail++; $display("FAIL parity_bit[%0d]: got x_valid=%b x=%b, expected 1 %b", k, x_valid, x, lit[8-k]);
            end
        end
        @(negedge clk);
        n_checks++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL parity_end: got x_valid=%b, expected 0", x_valid); end
    endtask
`endif

    initial begin
        test_reset();
        @(negedge clk);
        test_single();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_direct_chain();
        @(negedge clk);
        test_detector();
        @(negedge clk);
        test_reset_mid();
`ifdef SERIALIZER_PARITY_EN
        @(negedge clk);
        test_parity();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
